// File: rtl/jbi_pktout_pkg.sv
// Shared definitions for the JBus packet-out sequencer.
//   - request type codes presented on int_req_type
//   - J_AD mux select codes driven on sel_j_adbus
//   - sequencer state encoding
//   - queues whose read returns raise rd_ack (SCT queues)
//   - credit rule deciding whether a granted request may start
package jbi_pktout_pkg;

  localparam logic [3:0] REQ_NONE       = 4'd0;
  localparam logic [3:0] REQ_RD16       = 4'd1;
  localparam logic [3:0] REQ_RD64       = 4'd2;
  localparam logic [3:0] REQ_NCRD       = 4'd3;
  localparam logic [3:0] REQ_NCWR0      = 4'd4;
  localparam logic [3:0] REQ_NCWR4      = 4'd5;
  localparam logic [3:0] REQ_NCWR5      = 4'd6;
  localparam logic [3:0] REQ_NCWR_OTHER = 4'd7;
  localparam logic [3:0] REQ_INTACK     = 4'd8;
  localparam logic [3:0] REQ_INTNACK    = 4'd9;
  localparam logic [3:0] REQ_RDER       = 4'd10;

  localparam logic [3:0] SEL_NONE    = 4'd0;
  localparam logic [3:0] SEL_ADDR    = 4'd1;  // address/header from the request queue
  localparam logic [3:0] SEL_INT     = 4'd2;  // interrupt ack/nack header
  localparam logic [3:0] SEL_RD_DATA = 4'd3;  // read return data
  localparam logic [3:0] SEL_RDER    = 4'd4;  // read error return
  localparam logic [3:0] SEL_WR_DATA = 4'd5;  // non-cacheable write data

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRdData   = 2'd1,
    StNcwrData = 2'd2
  } pktout_state_e;

  // Queues 0..3 are SCT read-return queues; only these get rd_ack.
  localparam logic [14:0] SCT_RDACK_MASK = 15'h000f;

  function automatic logic req_credit_ok(input logic [3:0] req_type,
                                         input logic       mult_ok,
                                         input logic       addr_ok,
                                         input logic       data4_ok,
                                         input logic       data5_ok);
    logic ok;
    case (req_type)
      REQ_RD16, REQ_RDER, REQ_INTACK, REQ_INTNACK: ok = 1'b1;
      REQ_NCRD:                                    ok = addr_ok;
      REQ_RD64:                                    ok = mult_ok;
      REQ_NCWR0, REQ_NCWR_OTHER:                   ok = mult_ok & addr_ok;
      REQ_NCWR4:                                   ok = mult_ok & addr_ok & data4_ok;
      REQ_NCWR5:                                   ok = mult_ok & addr_ok & data5_ok;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Undefined codes behave exactly like NONE.
  function automatic logic req_is_none(input logic [3:0] req_type);
    return (req_type == REQ_NONE) || (req_type > REQ_RDER);
  endfunction

endpackage

// File: rtl/jbi_pktout_qenc.sv
// One-hot to queue-index encoder.
//   onehot : per-queue request vector (lowest set bit wins if several are set)
//   index  : 0 when no bit is set, otherwise bit position + 1
module jbi_pktout_qenc #(
  parameter int unsigned NQ = 7,
  parameter int unsigned QW = $clog2(NQ + 1)
) (
  input  logic [NQ-1:0] onehot,
  output logic [QW-1:0] index
);

  // Scan downwards so the lowest set bit is the final assignment.
  always_comb begin
    index = '0;
    for (int i = NQ - 1; i >= 0; i--) begin
      if (onehot[i]) index = QW'(i + 1);
    end
  end

endmodule

// File: rtl/jbi_pktout_seq.sv
// JBus packet-out sequencer.
// Turns a granted internal request (type + one-hot requestor) into a per-cycle J_AD select
// sequence with dequeue, JID alloc and read-ack strobes. All outputs are Mealy: the first
// packet cycle is driven in the grant cycle itself.
//
// Ports
//   clk, rst_l                      clock, asynchronous active-low reset
//   grant                           JBus arbiter grant
//   int_req_type, int_requestors    winning request type and one-hot queue
//   multiple_ok, ok_send_*          flow-control credits
//   int_granted                     winner accepted (packet cycle 0)
//   multiple_in_progress            packet continues beyond the next cycle
//   stream_break_point              JBus may re-arbitrate after this cycle
//   dequeue, rd_ack                 per-queue pop / read completion
//   jbus_out_addr_cycle/_data_cycle cycle kind
//   alloc                           allocate JID->PIO-ID entry (NCRD)
//   sel_j_adbus, sel_beat, sel_queue J_AD source, beat index, encoded queue (0 = none)
//
// Optional feature: define JBI_PKTOUT_STREAM_LIMIT_EN to force a stream break after
// MAX_STREAM back-to-back packets.
module jbi_pktout_seq
  import jbi_pktout_pkg::*;
#(
  parameter  int unsigned NQ              = 7,
  parameter  int unsigned RD_BEATS        = 4,
  parameter  int unsigned NCWR_DATA_BEATS = 1,
  parameter  int unsigned MAX_STREAM      = 4,
  localparam int unsigned QW              = $clog2(NQ + 1)
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          grant,
  input  logic [3:0]    int_req_type,
  input  logic [NQ-1:0] int_requestors,
  input  logic          multiple_ok,
  input  logic          ok_send_address_pkt,
  input  logic          ok_send_data_pkt_to_4,
  input  logic          ok_send_data_pkt_to_5,
  output logic          int_granted,
  output logic          multiple_in_progress,
  output logic          stream_break_point,
  output logic [NQ-1:0] dequeue,
  output logic [NQ-1:0] rd_ack,
  output logic          jbus_out_addr_cycle,
  output logic          jbus_out_data_cycle,
  output logic          alloc,
  output logic [3:0]    sel_j_adbus,
  output logic [2:0]    sel_beat,
  output logic [QW-1:0] sel_queue
);

  localparam logic [3:0]    RdLen   = 4'(RD_BEATS);
  localparam logic [3:0]    WrLen   = 4'(1 + NCWR_DATA_BEATS);
  localparam logic [NQ-1:0] SctMask = SCT_RDACK_MASK[NQ-1:0];

  pktout_state_e state_q, state_d;
  logic [3:0]    beat_q, beat_d;
  logic [NQ-1:0] req_q, req_d;

  logic          limit_hit, start, idle_brk;
  logic          active, last;
  logic [3:0]    cyc, cur_len;
  logic          k_rd, k_rder, k_ncrd, k_int, k_ncwr;
  logic [NQ-1:0] req_lo, vec_cur;
  logic [QW-1:0] qidx;

  // Keep only the lowest requestor so a multi-hot vector never pops two queues.
  assign req_lo  = int_requestors & (~int_requestors + NQ'(1));
  assign vec_cur = (state_q == StIdle) ? req_lo : req_q;

  jbi_pktout_qenc #(
    .NQ(NQ),
    .QW(QW)
  ) u_qenc (
    .onehot(vec_cur),
    .index (qidx)
  );

`ifdef JBI_PKTOUT_STREAM_LIMIT_EN
  logic [3:0] stream_cnt_q, stream_cnt_d;

  // Counts consecutive starts; any idle cycle without a start (including the forced
  // break) clears it. Beats inside a packet leave it untouched.
  always_comb begin
    stream_cnt_d = stream_cnt_q;
    if (state_q == StIdle) stream_cnt_d = start ? stream_cnt_q + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) stream_cnt_q <= 4'd0;
    else        stream_cnt_q <= stream_cnt_d;
  end
`else
  logic unused_max_stream;
  assign unused_max_stream = ^4'(MAX_STREAM);
`endif

  always_comb begin
    limit_hit = 1'b0;
`ifdef JBI_PKTOUT_STREAM_LIMIT_EN
    limit_hit = (stream_cnt_q == 4'(MAX_STREAM));
`endif
    start    = (state_q == StIdle) && grant && !limit_hit &&
               req_credit_ok(int_req_type, multiple_ok, ok_send_address_pkt,
                             ok_send_data_pkt_to_4, ok_send_data_pkt_to_5);
    idle_brk = (state_q == StIdle) && grant && (limit_hit || req_is_none(int_req_type));
  end

  // Packet kind, length and cycle index of the cycle being driven now.
  always_comb begin
    active  = 1'b0;
    cyc     = beat_q;
    cur_len = 4'd1;
    k_rd    = 1'b0;
    k_rder  = 1'b0;
    k_ncrd  = 1'b0;
    k_int   = 1'b0;
    k_ncwr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        active = start;
        cyc    = 4'd0;
        case (int_req_type)
          REQ_RD16: k_rd = 1'b1;
          REQ_RD64: begin
            k_rd    = 1'b1;
            cur_len = RdLen;
          end
          REQ_RDER:                 k_rder = 1'b1;
          REQ_NCRD:                 k_ncrd = 1'b1;
          REQ_INTACK, REQ_INTNACK:  k_int  = 1'b1;
          REQ_NCWR0, REQ_NCWR4, REQ_NCWR5, REQ_NCWR_OTHER: begin
            k_ncwr  = 1'b1;
            cur_len = WrLen;
          end
          default: ;
        endcase
      end
      StRdData: begin
        active  = 1'b1;
        k_rd    = 1'b1;
        cur_len = RdLen;
      end
      StNcwrData: begin
        active  = 1'b1;
        k_ncwr  = 1'b1;
        cur_len = WrLen;
      end
      default: ;
    endcase
  end

  assign last = (cyc + 4'd1 == cur_len);

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= StIdle;
      beat_q  <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      req_q   <= req_d;
    end
  end

  // Next state. Multi-cycle packets run to completion whatever grant does.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    req_d   = req_q;
    unique case (state_q)
      StIdle: begin
        if (start && (cur_len != 4'd1)) begin
          state_d = (int_req_type == REQ_RD64) ? StRdData : StNcwrData;
          beat_d  = 4'd1;
          req_d   = req_lo;
        end
      end
      StRdData, StNcwrData: begin
        if (last) begin
          state_d = StIdle;
          beat_d  = 4'd0;
          req_d   = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        beat_d  = 4'd0;
        req_d   = '0;
      end
    endcase
  end

  // Outputs. Gated by rst_l so they drop as soon as reset asserts, even with grant high.
  always_comb begin
    int_granted          = 1'b0;
    multiple_in_progress = 1'b0;
    stream_break_point   = 1'b0;
    dequeue              = '0;
    rd_ack               = '0;
    jbus_out_addr_cycle  = 1'b0;
    jbus_out_data_cycle  = 1'b0;
    alloc                = 1'b0;
    sel_j_adbus          = SEL_NONE;
    sel_beat             = 3'd0;
    sel_queue            = '0;
    if (rst_l && active) begin
      int_granted          = (state_q == StIdle);
      multiple_in_progress = (cyc + 4'd3 <= cur_len);
      // Break one cycle before the last beat, or on the only beat of a 1-cycle packet.
      stream_break_point   = (cur_len == 4'd1) || (cyc + 4'd2 == cur_len);
      dequeue              = vec_cur;
      rd_ack               = ((k_rd || k_rder) && last) ? (vec_cur & SctMask) : '0;
      jbus_out_addr_cycle  = k_ncrd || k_int || (k_ncwr && (cyc == 4'd0));
      jbus_out_data_cycle  = k_rd || k_rder || (k_ncwr && (cyc != 4'd0));
      alloc                = k_ncrd;
      sel_beat             = cyc[2:0];
      sel_queue            = qidx;
      if (k_rd)                          sel_j_adbus = SEL_RD_DATA;
      else if (k_rder)                   sel_j_adbus = SEL_RDER;
      else if (k_int)                    sel_j_adbus = SEL_INT;
      else if (k_ncwr && (cyc != 4'd0))  sel_j_adbus = SEL_WR_DATA;
      else                               sel_j_adbus = SEL_ADDR;
    end else if (rst_l && idle_brk) begin
      stream_break_point = 1'b1;
    end
  end

endmodule
